// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan: HUB75 panel scanner, one BCM bit-plane per pass (shift, latch, weighted display)
module hub75_bcm_scan #(
   parameter int PANEL_WIDTH = 64,
   parameter int ROW_ADDR_W  = 5,
   parameter int PIXEL_W     = 8,
   parameter int BASE_OE     = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   output logic                           rd_en,
   output logic [ROW_ADDR_W-1:0]          rd_row,
   output logic [$clog2(PANEL_WIDTH)-1:0] rd_col,
   input  logic [6*PIXEL_W-1:0]           rd_data,
   output logic                           hub75_r1,
   output logic                           hub75_g1,
   output logic                           hub75_b1,
   output logic                           hub75_r2,
   output logic                           hub75_g2,
   output logic                           hub75_b2,
   output logic                           hub75_clk,
   output logic                           hub75_lat,
   output logic                           hub75_oe_n,
   output logic [ROW_ADDR_W-1:0]          hub75_addr,
   output logic                           frame_done
);
   localparam int C_W = $clog2(PANEL_WIDTH);
   localparam int K_W = $clog2(PANEL_WIDTH + 1);
   localparam int P_W = $clog2(PIXEL_W);
   localparam int N_W = $clog2(BASE_OE) + PIXEL_W + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

   state_t                    state_q, state_d;
   logic [K_W-1:0]            k_q, k_d;
   logic                      ph_q, ph_d;
   logic [N_W-1:0]            cnt_q, cnt_d;
   logic [ROW_ADDR_W-1:0]     row_q, row_d;
   logic [P_W-1:0]            plane_q, plane_d;
   logic                      frame_d, last_plane, rd_en_d;
   logic [5:0][PIXEL_W-1:0]   ch;
   logic [5:0]                col_bits;

   assign ch = rd_data;
   for (genvar g = 0; g < 6; g++) begin : g_bits
      assign col_bits[g] = ch[g][plane_q];
   end

   assign last_plane = plane_q == P_W'(PIXEL_W - 1);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      plane_d = plane_q;
      frame_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SHIFT;
               k_d     = '0;
               ph_d    = 1'b0;
            end
         end
         SHIFT: begin
            if (!ph_q) ph_d = 1'b1;
            else if (k_q == K_W'(PANEL_WIDTH)) state_d = LATCH;
            else begin
               k_d  = k_q + K_W'(1);
               ph_d = 1'b0;
            end
         end
         LATCH: begin
            state_d = DISPLAY;
            cnt_d   = (N_W'(BASE_OE) << plane_q) - N_W'(1);
         end
         DISPLAY: begin
            if (cnt_q != '0) cnt_d = cnt_q - N_W'(1);
            else begin
               // plane/row advance happens on the final display cycle
               plane_d = last_plane ? '0 : plane_q + P_W'(1);
               row_d   = last_plane ? row_q + ROW_ADDR_W'(1) : row_q;
               frame_d = last_plane && (&row_q);
               state_d = enable ? SHIFT : IDLE;
               k_d     = '0;
               ph_d    = 1'b0;
               if (!enable) begin
                  row_d   = '0;
                  plane_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      rd_en_d = state_d == SHIFT && !ph_d && k_d < K_W'(PANEL_WIDTH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         k_q        <= '0;
         ph_q       <= 1'b0;
         cnt_q      <= '0;
         row_q      <= '0;
         plane_q    <= '0;
         rd_en      <= 1'b0;
         rd_row     <= '0;
         rd_col     <= '0;
         {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} <= '0;
         hub75_clk  <= 1'b0;
         hub75_lat  <= 1'b0;
         hub75_oe_n <= 1'b1;
         hub75_addr <= '0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         ph_q       <= ph_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         plane_q    <= plane_d;
         rd_en      <= rd_en_d;
         rd_row     <= rd_en_d ? row_d : '0;
         rd_col     <= rd_en_d ? k_d[C_W-1:0] : '0;
         hub75_clk  <= state_d == SHIFT && ph_d && k_d != '0;
         hub75_lat  <= state_d == LATCH;
         hub75_oe_n <= state_d != DISPLAY;
         frame_done <= frame_d;
         if (state_d == LATCH) hub75_addr <= row_q;
         // read data for slot k arrives in phase 1 and is presented during slot k+1
         if (state_q == SHIFT && ph_q && k_q < K_W'(PANEL_WIDTH))
            {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} <= col_bits;
      end
   end
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// tb_hub75_bcm_scan: directed per-plane vectors plus enable-drop and reset corner sequences
module tb_hub75_bcm_scan;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        rd_en;
   logic [0:0]  rd_row;
   logic [1:0]  rd_col;
   logic [11:0] rd_data = '0;
   logic        hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2;
   logic        hub75_clk, hub75_lat, hub75_oe_n, frame_done;
   logic [0:0]  hub75_addr;
   logic [11:0] fb [2][4];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic            addr;
      int              period;
      int              oe_len;
      logic [3:0][5:0] bits;
      logic            fd;
   } vec_t;

   vec_t vt [8];

   localparam logic [23:0] R0P0 = {6'b010100, 6'b101000, 6'b000010, 6'b100001};
   localparam logic [23:0] R0P1 = {6'b010010, 6'b001001, 6'b010000, 6'b000101};
   localparam logic [23:0] R1P0 = {6'b101011, 6'b010111, 6'b111101, 6'b011110};
   localparam logic [23:0] R1P1 = {6'b101101, 6'b110110, 6'b101111, 6'b111010};

   hub75_bcm_scan #(.PANEL_WIDTH(4), .ROW_ADDR_W(1), .PIXEL_W(2), .BASE_OE(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .hub75_r1(hub75_r1), .hub75_g1(hub75_g1), .hub75_b1(hub75_b1),
      .hub75_r2(hub75_r2), .hub75_g2(hub75_g2), .hub75_b2(hub75_b2),
      .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n),
      .hub75_addr(hub75_addr), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= fb[rd_row][rd_col];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // entered on the first cycle of a plane; returns on the first cycle of the following one
   task automatic check_plane(input vec_t v, input int drop_at);
      int cyc = 0, edges = 0, oe_len = 0, lats = 0, fds = 0, viol = 0;
      logic prev = 1'b0;
      logic [3:0][5:0] got = '0;
      chk("start_rd_en", rd_en, 1);
      chk("start_rd_col", rd_col, 0);
      chk("start_rd_row", rd_row, v.addr);
      while (1) begin
         if (oe_len > 0 && hub75_oe_n) break;
         if (cyc > 60) begin
            chk("plane_timeout", cyc, v.period);
            break;
         end
         if (cyc == drop_at) enable = 1'b0;
         if (hub75_clk && !prev) begin
            got = {{hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2}, got[3:1]};
            edges++;
         end
         prev = hub75_clk;
         if (hub75_lat) begin
            lats++;
            chk("lat_oe_n", hub75_oe_n, 1);
            chk("lat_addr", hub75_addr, v.addr);
         end
         if (!hub75_oe_n) begin
            oe_len++;
            if (hub75_lat || hub75_clk) viol++;
         end
         if (cyc > 0 && frame_done) fds++;
         cyc++;
         @(posedge clk);
         #1;
      end
      chk("period", cyc, v.period);
      chk("oe_len", oe_len, v.oe_len);
      chk("edges", edges, 4);
      chk("lat_count", lats, 1);
      chk("shift_bits", got, v.bits);
      chk("oe_overlap", viol, 0);
      chk("frame_done_stray", fds, 0);
      chk("frame_done_end", frame_done, v.fd);
   endtask

   initial begin
      int n;
      fb[0][0] = 12'h423; fb[0][1] = 12'h204; fb[0][2] = 12'h4C2; fb[0][3] = 12'h318;
      fb[1][0] = 12'hBDC; fb[1][1] = 12'hDFB; fb[1][2] = 12'hB3D; fb[1][3] = 12'hCE7;
      vt[0] = '{1'b0, 13, 2, R0P0, 1'b0};
      vt[1] = '{1'b0, 15, 4, R0P1, 1'b0};
      vt[2] = '{1'b1, 13, 2, R1P0, 1'b0};
      vt[3] = '{1'b1, 15, 4, R1P1, 1'b1};
      vt[4] = '{1'b0, 13, 2, R0P0, 1'b0};
      vt[5] = '{1'b0, 15, 4, R0P1, 1'b0};
      vt[6] = '{1'b0, 13, 2, R0P0, 1'b0};
      vt[7] = '{1'b0, 15, 4, R0P1, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe_n", hub75_oe_n, 1);
      chk("rst_outs", {rd_en, rd_row, rd_col, hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2,
                       hub75_b2, hub75_clk, hub75_lat, hub75_addr, frame_done}, 0);
      rst_n = 1'b1;
      n = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (rd_en) n++;
      end
      chk("idle_rd_en", n, 0);
      chk("idle_oe_n", hub75_oe_n, 1);

      enable = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) check_plane(vt[i], -1);

      check_plane(vt[5], 3);
      chk("drop_rd_en", rd_en, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("drop_idle_oe_n", hub75_oe_n, 1);
      chk("drop_idle_outs", {rd_en, hub75_clk, hub75_lat}, 0);

      enable = 1'b1;
      @(posedge clk);
      #1;
      check_plane(vt[6], -1);
      check_plane(vt[7], -1);

      n = 0;
      while (hub75_oe_n && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("disp_reached", hub75_oe_n, 0);
      chk("disp_addr", hub75_addr, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_oe_n", hub75_oe_n, 1);
      chk("mid_rst_addr", hub75_addr, 0);
      chk("mid_rst_outs", {rd_en, hub75_clk, hub75_lat, frame_done}, 0);
      rst_n = 1'b1;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", {rd_en, hub75_oe_n}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hub75_bcm_scan.md
Name: hub75_bcm_scan

Overview:
- Downstream consumer of the gamma correction stage in the HUB75 driver.
- Reads gamma-corrected pixel pairs (upper and lower half-panel) from the framebuffer read path. Gamma correction is combinational, so the read path has 1-cycle latency.
- Drives the HUB75 panel pins using binary-coded modulation (BCM): per scan row, shifts one bit-plane per pass, latches it, then enables the display for a time weighted by 2^bit.
- Sequential scheme: shifting and display do not overlap.

Parameters:
- PANEL_WIDTH, 64, columns per row; must be ≥2.
- ROW_ADDR_W, 5, scan row address width; scan rows = 2^ROW_ADDR_W.
- PIXEL_W, 8, bits per colour channel; equals the gamma stage pixel width.
- BASE_OE, 4, display cycles for bit-plane 0; plane b displays BASE_OE<<b cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  run scanning.
- rd_en  out  1  framebuffer read strobe.
- rd_row  out  ROW_ADDR_W  read scan row.
- rd_col  out  $clog2(PANEL_WIDTH)  read column.
- rd_data  in  6*PIXEL_W  gamma-corrected data, packed {r1,g1,b1,r2,g2,b2}, MSB first; valid 1 cycle after rd_en.
- hub75_r1 / hub75_g1 / hub75_b1 / hub75_r2 / hub75_g2 / hub75_b2  out  1 each  colour data bits.
- hub75_clk  out  1  panel shift clock.
- hub75_lat  out  1  latch strobe.
- hub75_oe_n  out  1  output enable, active low.
- hub75_addr  out  ROW_ADDR_W  displayed row address.
- frame_done  out  1  one-cycle pulse after the last row/plane of a frame completes display.

Behaviour:
- Reset behaviour:
  - Reset is synchronous active-low; `clk` is the only clock. All outputs are registered.
  - Reset values: oe_n=1, all other outputs 0, state=IDLE, row=0, plane=0.
  - Reset mid-operation aborts immediately to these values.
- IDLE: oe_n=1. When enable=1, go to SHIFT with the current row/plane.
- SHIFT: 2*(PANEL_WIDTH+1) cycles, organised as slots k=0..PANEL_WIDTH, two phases each.
  - Phase 0: hub75_clk=0. If k<PANEL_WIDTH: rd_en=1, rd_col=k, rd_row=row; otherwise rd_en=0.
  - Phase 1: hub75_clk=1 if k>0, else 0. If k<PANEL_WIDTH, the colour outputs load bit [plane] of each channel of rd_data at the end of this phase.
  - Result: column k is presented during slot k+1 and sampled on that slot's rising edge.
  - Exactly PANEL_WIDTH rising edges per SHIFT. The first shifted bit is column 0.
  - oe_n=1 and lat=0 throughout.
- LATCH: 1 cycle.
  - hub75_addr<=row, lat=1, oe_n=1, hub75_clk=0.
- DISPLAY: oe_n=0 for exactly BASE_OE<<plane cycles; lat=0.
  - Colour outputs hold their last value.
  - At the last cycle, advance counters:
    - plane+1.
    - If plane was PIXEL_W-1: plane=0, row+1.
    - If row was the last: row wraps to 0 and frame_done=1 for the next cycle.
- After DISPLAY:
  - If enable=1, go to SHIFT.
  - If enable=0, go to IDLE with row=0, plane=0, oe_n=1.
- Enable deassertion: only sampled in IDLE and at the end of DISPLAY. A deassertion mid-SHIFT or mid-LATCH completes the current plane first.
- Timing per plane: 2*(PANEL_WIDTH+1) + 1 + (BASE_OE<<plane) cycles. No idle gaps between planes.
- rd_data bit slicing: for channel index i (r1=5 … b2=0), bit = rd_data[i*PIXEL_W + plane].

Test Plan:
- Common configuration: PANEL_WIDTH=4, ROW_ADDR_W=1, PIXEL_W=2, BASE_OE=2. Framebuffer model has 1-cycle latency.
- Reset/idle: rst_n=0 for 3 cycles, enable=0 → oe_n=1, all other outputs 0, rd_en never asserted.
- Single plane shift: enable=1, columns 0..3 return r1 values 2'b01,2'b00,2'b01,2'b00 → on plane 0, r1 sampled at hub75_clk rising edges = 1,0,1,0. Exactly 4 rising edges in 10 cycles, then lat high 1 cycle with oe_n=1.
- BCM weighting: measure oe_n low duration → plane 0 = 2 cycles, plane 1 = 4 cycles. Per-plane period 13 and 15 cycles; never oe_n=0 while lat=1 or hub75_clk toggles.
- Row/frame wrap: run continuously → hub75_addr sequence 0,0,1,1,0… per latch. frame_done pulses once every 56 cycles, in the cycle after row 1 plane 1 display ends.
- Enable drop mid-SHIFT: deassert enable at cycle 3 of SHIFT → current plane finishes LATCH and DISPLAY, then IDLE with oe_n=1. Re-enable restarts at row 0 plane 0, rd_col=0.
- Reset mid-DISPLAY: rst_n=0 while oe_n=0 → next cycle oe_n=1, addr=0, state IDLE.
